// File: rtl/out_capture_pkg.sv
// Shared types and defaults for the OUT-port capture block.
// Optional build macro used by the top: OUT_CAPTURE_TIMESTAMP_EN.
package out_capture_pkg;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } cap_state_e;

   localparam int OUTCAP_DATA_W = 16;
   localparam int OUTCAP_DEPTH  = 8;
   localparam int OUTCAP_STAMP_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push/pop must already be qualified by the caller.
// Pointers carry an extra wrap bit so full and empty are unambiguous.
module sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: contents are only visible through a valid head.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;
   assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/out_port_capture.sv
// Captures CPU OUT values into a FIFO, tracks halt, and offers a drain port.
// Define OUT_CAPTURE_TIMESTAMP_EN to store a 16-bit cycle stamp per word (rd_stamp).
module out_port_capture
   import out_capture_pkg::*;
#(
   parameter int DATA_W = OUTCAP_DATA_W,
   parameter int DEPTH  = OUTCAP_DEPTH,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     out_we,
   input  logic [DATA_W-1:0]        out_data,
   input  logic                     done,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         total,
   output logic                     overflow,
   output logic                     halted,
   output logic                     drained,
   output cap_state_e               dbg_state
`ifdef OUT_CAPTURE_TIMESTAMP_EN
   ,
   output logic [OUTCAP_STAMP_W-1:0] rd_stamp
`endif
);

   // Read handshake: a word transfers on a rising edge where rd_valid && rd_ready;
   // rd_valid never depends on rd_ready, and rd_data holds while valid and not ready.

`ifdef OUT_CAPTURE_TIMESTAMP_EN
   localparam int FW = DATA_W + OUTCAP_STAMP_W;
`else
   localparam int FW = DATA_W;
`endif

   cap_state_e state, next_state;

   logic          fifo_full;
   logic          fifo_empty;
   logic          push_req;
   logic          push_ok;
   logic          pop_ok;
   logic [FW-1:0] fifo_wdata;
   logic [FW-1:0] fifo_rdata;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= ST_RUN;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      push_req   = 1'b0;
      case (state)
         ST_RUN: begin
            push_req = out_we;
            if (done) next_state = ST_HALTED;
         end
         ST_HALTED: next_state = ST_HALTED;
         default:   next_state = ST_RUN;
      endcase
   end

   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign pop_ok  = rd_ready && !fifo_empty;
   assign push_ok = push_req && (!fifo_full || pop_ok);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         total    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok && (total != '1)) total <= total + CNT_W'(1);
         if (push_req && !push_ok)     overflow <= 1'b1;
      end
   end

`ifdef OUT_CAPTURE_TIMESTAMP_EN
   logic [OUTCAP_STAMP_W-1:0] cycle_cnt;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) cycle_cnt <= '0;
      else     cycle_cnt <= cycle_cnt + 1'b1;
   end

   assign fifo_wdata = {cycle_cnt, out_data};
   assign rd_stamp   = fifo_rdata[FW-1:DATA_W];
`else
   assign fifo_wdata = out_data;
`endif

   sync_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (push_ok),
      .pop   (pop_ok),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign rd_valid  = !fifo_empty;
   assign rd_data   = fifo_rdata[DATA_W-1:0];
   assign halted    = (state == ST_HALTED);
   assign drained   = halted && fifo_empty;
   assign dbg_state = state;

endmodule

// File: tb/tb_out_port_capture.sv
// Directed plus random bench for out_port_capture against a queue-based model.
module tb_out_port_capture;
   import out_capture_pkg::*;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   logic              out_we;
   logic [DATA_W-1:0] out_data;
   logic              done;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [3:0]        level;
   logic [CNT_W-1:0]  total;
   logic              overflow;
   logic              halted;
   logic              drained;
   cap_state_e        dbg_state;
`ifdef OUT_CAPTURE_TIMESTAMP_EN
   logic [15:0]       rd_stamp;
`endif

   out_port_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .clr       (clr),
      .out_we    (out_we),
      .out_data  (out_data),
      .done      (done),
      .rd_ready  (rd_ready),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .level     (level),
      .total     (total),
      .overflow  (overflow),
      .halted    (halted),
      .drained   (drained),
      .dbg_state (dbg_state)
`ifdef OUT_CAPTURE_TIMESTAMP_EN
      ,
      .rd_stamp  (rd_stamp)
`endif
   );

   // ---------------- reference model ----------------
   logic [DATA_W-1:0] exp_q[$];
   logic [15:0]       stamp_q[$];
   int                m_total;
   bit                m_overflow;
   bit                m_halted;
   logic [15:0]       tb_cyc;
   int                checks = 0;
   int                errors = 0;

   // Cycles elapsed since reset, as a cycle stamp should read at each edge.
   always @(posedge clk or posedge clr) begin
      if (clr) tb_cyc <= '0;
      else     tb_cyc <= tb_cyc + 16'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [DATA_W-1:0] head;
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() > 0));
      chk("rd_data",  32'(rd_data),  32'(head));
      chk("level",    32'(level),    32'(exp_q.size()));
      chk("total",    32'(total),    32'(m_total));
      chk("overflow", 32'(overflow), 32'(m_overflow));
      chk("halted",   32'(halted),   32'(m_halted));
      chk("drained",  32'(drained),  32'(m_halted && exp_q.size() == 0));
      chk("state",    32'(dbg_state == ST_HALTED), 32'(m_halted));
`ifdef OUT_CAPTURE_TIMESTAMP_EN
      chk("rd_stamp", 32'(rd_stamp), 32'((stamp_q.size() > 0) ? stamp_q[0] : 16'd0));
`endif
   endtask

   task automatic model_reset();
      exp_q.delete();
      stamp_q.delete();
      m_total    = 0;
      m_overflow = 0;
      m_halted   = 0;
   endtask

   // ---------------- driver tasks ----------------
   // Drive one cycle's inputs at the falling edge, check, then update the model for the edge.
   task automatic cycle(input logic we, input logic [DATA_W-1:0] d, input logic dn, input logic rdy);
      int  n;
      bit  pop;
      @(negedge clk);
      out_we = we; out_data = d; done = dn; rd_ready = rdy;
      #1;
      check_outputs();
      n   = exp_q.size();
      pop = rdy && (n > 0);
      if (we && !m_halted) begin
         if (n < DEPTH || pop) begin
            exp_q.push_back(d);
            stamp_q.push_back(tb_cyc);
            if (m_total < (1 << CNT_W) - 1) m_total++;
         end else begin
            m_overflow = 1;
         end
      end
      if (pop) begin
         void'(exp_q.pop_front());
         void'(stamp_q.pop_front());
      end
      if (dn) m_halted = 1;
      @(posedge clk);
   endtask

   // Asynchronous clr pulse placed between clock edges.
   task automatic async_reset();
      @(posedge clk);
      #2;
      out_we = 0; done = 0; rd_ready = 0;
      clr = 1;
      model_reset();
      #1;
      check_outputs();
      #1;
      clr = 0;
   endtask

   logic [DATA_W-1:0] basic_vals[5] = '{16'h6325, 16'h0047, 16'h0089, 16'h00D0, 16'hFFBE};

   // ---------------- stimulus ----------------
   initial begin
      clr = 1; out_we = 0; out_data = '0; done = 0; rd_ready = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_outputs();
      clr = 0;

      // Basic program flow
      for (int i = 0; i < 5; i++) cycle(1, basic_vals[i], 0, 0);
      cycle(0, '0, 1, 0);
      for (int i = 0; i < 7; i++) cycle(0, '0, 1, 1);
      async_reset();

      // Overflow: nine words into eight slots
      for (int i = 1; i <= 9; i++) cycle(1, DATA_W'(i), 0, 0);
      for (int i = 0; i < 9; i++) cycle(0, '0, 0, 1);
      async_reset();

      // Full with simultaneous push and pop
      for (int i = 1; i <= 8; i++) cycle(1, DATA_W'(16'h0100 + i), 0, 0);
      cycle(1, 16'hAAAA, 0, 1);
      for (int i = 0; i < 9; i++) cycle(0, '0, 0, 1);
      async_reset();

      // Halt gating
      cycle(1, 16'h1234, 1, 0);
      cycle(1, 16'h5678, 1, 0);
      cycle(0, '0, 0, 0);
      cycle(0, '0, 0, 1);
      cycle(0, '0, 0, 0);
      async_reset();

      // Async reset mid-drain with three entries held
      for (int i = 0; i < 4; i++) cycle(1, DATA_W'($urandom), 0, 0);
      cycle(0, '0, 0, 1);
      async_reset();

      // Timestamp pattern: pushes at cycles 3 and 10 after reset
      for (int c = 0; c < 14; c++)
         cycle((c == 3 || c == 10), DATA_W'(16'hC000 + c), 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, '0, 0, 1);
      async_reset();

      // Random traffic with occasional halt and reset
      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 149) async_reset();
         else cycle(($urandom_range(0, 2) != 0), DATA_W'($urandom),
                    ($urandom_range(0, 80) == 0), ($urandom_range(0, 2) == 0));
      end
      cycle(0, '0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
